// File: rtl/bldc_pkg.sv
// Shared types and lookup helpers for the BLDC six-step commutator.
package bldc_pkg;

    localparam int unsigned HALL_W = 3;
    localparam int unsigned SECT_W = 3;
    localparam int unsigned PH_N   = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {REQ_OFF = 2'd0, REQ_HI = 2'd1, REQ_LO = 2'd2} phase_req_t;
    typedef enum logic [1:0] {ST_OFF = 2'd0, ST_HI = 2'd1, ST_LO = 2'd2, ST_DEAD = 2'd3} phase_st_t;

    localparam logic [HALL_W-1:0] INVALID_HALL_LO = 3'b000;
    localparam logic [HALL_W-1:0] INVALID_HALL_HI = 3'b111;

    typedef struct packed {
        logic              valid;
        logic [SECT_W-1:0] sector;
    } hall_dec_t;

    // One-hot phase masks {C,B,A} for the high and low side of a sector
    typedef struct packed {
        logic [PH_N-1:0] hi;
        logic [PH_N-1:0] lo;
    } phase_pair_t;

    function automatic hall_dec_t hall_decode(input logic [HALL_W-1:0] code);
        hall_dec_t d;
        d.valid  = 1'b1;
        d.sector = 3'd0;
        case (code)
            3'b101: d.sector = 3'd0;
            3'b100: d.sector = 3'd1;
            3'b110: d.sector = 3'd2;
            3'b010: d.sector = 3'd3;
            3'b011: d.sector = 3'd4;
            3'b001: d.sector = 3'd5;
            INVALID_HALL_LO, INVALID_HALL_HI: d.valid = 1'b0;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Reverse rotation uses the sector half a turn away
    function automatic logic [SECT_W-1:0] eff_sector(input logic [SECT_W-1:0] s, input logic rev);
        logic [SECT_W-1:0] e;
        e = s;
        if (rev) e = (s >= 3'd3) ? s - 3'd3 : s + 3'd3;
        return e;
    endfunction

    function automatic phase_pair_t sector_pair(input logic [SECT_W-1:0] e);
        phase_pair_t p;
        p = '0;
        case (e)
            3'd0: begin p.hi = 3'b001; p.lo = 3'b010; end
            3'd1: begin p.hi = 3'b001; p.lo = 3'b100; end
            3'd2: begin p.hi = 3'b010; p.lo = 3'b100; end
            3'd3: begin p.hi = 3'b010; p.lo = 3'b001; end
            3'd4: begin p.hi = 3'b100; p.lo = 3'b001; end
            3'd5: begin p.hi = 3'b100; p.lo = 3'b010; end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bldc_deadtime_phase.sv
// One inverter leg: turns a phase request into high/low gate drive with a
// dead interval after either gate switches off.
module bldc_deadtime_phase
    import bldc_pkg::*;
#(
    parameter int unsigned DEADTIME_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  phase_req_t req,
    output logic       gate_hi,
    output logic       gate_lo
);

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME_CYC - 1);

    phase_st_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State register; gates are registered copies of the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_OFF;
            cnt     <= '0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gate_hi <= (state_nxt == ST_HI);
            gate_lo <= (state_nxt == ST_LO);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_OFF: begin
                if (req == REQ_HI)      state_nxt = ST_HI;
                else if (req == REQ_LO) state_nxt = ST_LO;
            end
            ST_HI: begin
                if (req != REQ_HI) begin
                    state_nxt = ST_DEAD;
                    cnt_nxt   = DEAD_LOAD;
                end
            end
            ST_LO: begin
                if (req != REQ_LO) begin
                    state_nxt = ST_DEAD;
                    cnt_nxt   = DEAD_LOAD;
                end
            end
            ST_DEAD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    case (req)
                        REQ_HI:  state_nxt = ST_HI;
                        REQ_LO:  state_nxt = ST_LO;
                        default: state_nxt = ST_OFF;
                    endcase
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: filtered Hall decode, sector-to-gate mapping and
// per-phase dead-time legs, with a latched fault on invalid Hall codes.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int unsigned DEADTIME_CYC = 16,
    parameter int unsigned HALL_FILT    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              dir,
    input  logic              pwm_in,
    input  logic [HALL_W-1:0] hall,
    input  logic              fault_clr,
    output logic [PH_N-1:0]   gate_hi,
    output logic [PH_N-1:0]   gate_lo,
    output logic [SECT_W-1:0] sector,
    output logic              commutate,
    output logic              fault
);

    localparam logic [CNT_W-1:0] FILT_N = CNT_W'(HALL_FILT);

    logic [HALL_W-1:0] hall_s1, hall_s2, hall_cand;
    logic [1:0]        sync_vld;
    logic [CNT_W-1:0]  filt_cnt, filt_run;
    logic              hall_valid;
    logic              accept, fault_set, drive_ok;
    hall_dec_t         dec;
    phase_pair_t       pair;
    phase_req_t        req [PH_N];

    // Filter only runs once the synchroniser holds real samples
    always_comb begin
        filt_run = CNT_W'(1);
        if (hall_s2 == hall_cand) filt_run = (&filt_cnt) ? filt_cnt : filt_cnt + CNT_W'(1);
        accept    = sync_vld[1] && (filt_run >= FILT_N);
        dec       = hall_decode(hall_s2);
        fault_set = accept && !dec.valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hall_s1    <= '0;
            hall_s2    <= '0;
            sync_vld   <= '0;
            hall_cand  <= '0;
            filt_cnt   <= '0;
            hall_valid <= 1'b0;
            sector     <= '0;
            commutate  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            hall_s1   <= hall;
            hall_s2   <= hall_s1;
            sync_vld  <= {sync_vld[0], 1'b1};
            commutate <= 1'b0;
            if (sync_vld[1]) begin
                hall_cand <= hall_s2;
                filt_cnt  <= filt_run;
            end
            if (accept) begin
                if (dec.valid) begin
                    sector     <= dec.sector;
                    hall_valid <= 1'b1;
                    commutate  <= !hall_valid || (dec.sector != sector);
                end else begin
                    hall_valid <= 1'b0;
                end
            end
            // An invalid code outranks a simultaneous clear
            if (fault_set)                     fault <= 1'b1;
            else if (fault_clr && hall_valid)  fault <= 1'b0;
        end
    end

    always_comb begin
        drive_ok = enable && !fault && hall_valid;
        pair     = sector_pair(eff_sector(sector, dir));
        for (int i = 0; i < PH_N; i++) begin
            req[i] = REQ_OFF;
            if (drive_ok) begin
                if (pair.hi[i] && pwm_in) req[i] = REQ_HI;
                else if (pair.lo[i])      req[i] = REQ_LO;
            end
        end
    end

    for (genvar i = 0; i < PH_N; i++) begin : g_phase
        bldc_deadtime_phase #(
            .DEADTIME_CYC(DEADTIME_CYC)
        ) u_phase (
            .clk     (clk),
            .reset   (reset),
            .req     (req[i]),
            .gate_hi (gate_hi[i]),
            .gate_lo (gate_lo[i])
        );
    end

endmodule
